// File: rtl/ctrl_pkg.sv
// ctrl_pkg: control-bundle layout, encodings and stage bundles for
// the MIPS pipeline control path.
package ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int CTRL_W = 10;

  localparam int B_REGDST   = 9;
  localparam int B_ALUSRC   = 8;
  localparam int B_MEMTOREG = 7;
  localparam int B_REGWRITE = 6;
  localparam int B_MEMREAD  = 5;
  localparam int B_MEMWRITE = 4;
  localparam int B_BRANCH   = 3;
  localparam int B_JUMP     = 2;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef logic [REG_W-1:0] reg_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       memto_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    reg_t  rs;
    reg_t  rt;
    reg_t  wreg;
  } id_ex_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic memto_reg;
    reg_t wreg;
  } ex_mem_t;

  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    reg_t wreg;
  } mem_wb_t;

  // $0 is hardwired, so it can never be a dependency
  function automatic logic reg_hit(input logic en,
                                   input reg_t w,
                                   input reg_t r);
    return en && (w != '0) && (w == r);
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard.sv
// hazard_unit: combinational stall, flush, pc_src and forward select.
// CTRL_PIPE_FWD_EN selects forwarding instead of full RAW stalls.
module hazard_unit
  import ctrl_pkg::*;
(
  input  logic       id_jump_i,
  input  reg_t       id_rs_i,
  input  reg_t       id_rt_i,
  input  logic       ex_memread_i,
  input  logic       ex_regwrite_i,
  input  reg_t       ex_rs_i,
  input  reg_t       ex_rt_i,
  input  reg_t       ex_wreg_i,
  input  logic       mem_branch_i,
  input  logic       mem_zero_i,
  input  logic       mem_regwrite_i,
  input  reg_t       mem_wreg_i,
  input  logic       wb_regwrite_i,
  input  reg_t       wb_wreg_i,
  output logic       pc_hold_o,
  output logic       bubble_o,
  output logic       kill_o,
  output logic       if_flush_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  logic taken;
  logic load_use;
  logic raw;
  logic stall;
  logic jump_go;

  assign taken = mem_branch_i & mem_zero_i;

  assign load_use =
    reg_hit(ex_memread_i, ex_wreg_i, id_rs_i) |
    reg_hit(ex_memread_i, ex_wreg_i, id_rt_i);

`ifdef CTRL_PIPE_FWD_EN
  logic unused_raw;
  assign unused_raw = ex_regwrite_i;
  assign raw = 1'b0;

  assign fwd_a_o =
    reg_hit(mem_regwrite_i, mem_wreg_i, ex_rs_i) ? FWD_MEM :
    reg_hit(wb_regwrite_i, wb_wreg_i, ex_rs_i)   ? FWD_WB  :
                                                   FWD_RF;
  assign fwd_b_o =
    reg_hit(mem_regwrite_i, mem_wreg_i, ex_rt_i) ? FWD_MEM :
    reg_hit(wb_regwrite_i, wb_wreg_i, ex_rt_i)   ? FWD_WB  :
                                                   FWD_RF;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_rs_i, ex_rt_i, wb_regwrite_i, wb_wreg_i};

  // WB needs no stall: the register file writes early in the cycle
  assign raw =
    reg_hit(ex_regwrite_i, ex_wreg_i, id_rs_i) |
    reg_hit(ex_regwrite_i, ex_wreg_i, id_rt_i) |
    reg_hit(mem_regwrite_i, mem_wreg_i, id_rs_i) |
    reg_hit(mem_regwrite_i, mem_wreg_i, id_rt_i);

  assign fwd_a_o = FWD_RF;
  assign fwd_b_o = FWD_RF;
`endif

  assign stall   = load_use | raw;
  assign jump_go = id_jump_i & ~stall & ~taken;

  assign pc_hold_o  = stall & ~taken;
  assign bubble_o   = stall | taken;
  assign kill_o     = taken;
  assign if_flush_o = taken | jump_go;

  always_comb begin
    pc_src_o = PC_SEQ;
    unique case (1'b1)
      taken:   pc_src_o = PC_BR;
      jump_go: pc_src_o = PC_JMP;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM and MEM/WB control carrier for the MIPS core.
// Define CTRL_PIPE_FWD_EN to build with operand forwarding.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              mem_zero,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_wreg,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_regwrite,
  output logic              mem_memtoreg,
  output logic [REG_W-1:0]  mem_wreg,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_W-1:0]  wb_wreg,
  output logic              pc_hold,
  output logic              if_flush,
  output logic [1:0]        pc_src,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  id_ex_t  idex_q, idex_d;
  ex_mem_t exmem_q, exmem_d;
  mem_wb_t memwb_q, memwb_d;
  logic    bubble;
  logic    kill;

  hazard_unit u_hazard (
    .id_jump_i      (id_ctrl[B_JUMP]),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .ex_memread_i   (idex_q.ctrl.mem_read),
    .ex_regwrite_i  (idex_q.ctrl.reg_write),
    .ex_rs_i        (idex_q.rs),
    .ex_rt_i        (idex_q.rt),
    .ex_wreg_i      (idex_q.wreg),
    .mem_branch_i   (exmem_q.branch),
    .mem_zero_i     (mem_zero),
    .mem_regwrite_i (exmem_q.reg_write),
    .mem_wreg_i     (exmem_q.wreg),
    .wb_regwrite_i  (memwb_q.reg_write),
    .wb_wreg_i      (memwb_q.wreg),
    .pc_hold_o      (pc_hold),
    .bubble_o       (bubble),
    .kill_o         (kill),
    .if_flush_o     (if_flush),
    .pc_src_o       (pc_src),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b)
  );

  always_comb begin
    idex_d = '0;
    if (!bubble) begin
      idex_d.ctrl = ctrl_t'(id_ctrl);
      idex_d.rs   = id_rs;
      idex_d.rt   = id_rt;
      idex_d.wreg = id_ctrl[B_REGDST] ? id_rd : id_rt;
    end
  end

  always_comb begin
    exmem_d = '0;
    if (!kill) begin
      exmem_d.branch    = idex_q.ctrl.branch;
      exmem_d.mem_read  = idex_q.ctrl.mem_read;
      exmem_d.mem_write = idex_q.ctrl.mem_write;
      exmem_d.reg_write = idex_q.ctrl.reg_write;
      exmem_d.memto_reg = idex_q.ctrl.memto_reg;
      exmem_d.wreg      = idex_q.wreg;
    end
  end

  always_comb begin
    memwb_d           = '0;
    memwb_d.reg_write = exmem_q.reg_write;
    memwb_d.memto_reg = exmem_q.memto_reg;
    memwb_d.wreg      = exmem_q.wreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_ctrl      = idex_q.ctrl;
  assign ex_rs        = idex_q.rs;
  assign ex_rt        = idex_q.rt;
  assign ex_wreg      = idex_q.wreg;
  assign mem_memread  = exmem_q.mem_read;
  assign mem_memwrite = exmem_q.mem_write;
  assign mem_regwrite = exmem_q.reg_write;
  assign mem_memtoreg = exmem_q.memto_reg;
  assign mem_wreg     = exmem_q.wreg;
  assign wb_regwrite  = memwb_q.reg_write;
  assign wb_memtoreg  = memwb_q.memto_reg;
  assign wb_wreg      = memwb_q.wreg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed and randomized checks of ctrl_pipe against an
// instruction-level pipeline model.
module tb_ctrl_pipe;

  typedef struct packed {
    logic [9:0] c;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } ins_t;

  typedef struct packed {
    logic       hold;
    logic       flush;
    logic [1:0] psrc;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       taken;
    logic       stall;
  } ctl_t;

  localparam logic [9:0] C_R   = 10'b1001000010;
  localparam logic [9:0] C_LW  = 10'b0111100000;
  localparam logic [9:0] C_SW  = 10'b0100010000;
  localparam logic [9:0] C_BEQ = 10'b0000001001;
  localparam logic [9:0] C_J   = 10'b0000000100;
  localparam logic [9:0] C_NOP = 10'b0000000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] id_ctrl = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic [4:0] id_rd = '0;
  logic       mem_zero = 1'b0;
  logic [9:0] ex_ctrl;
  logic [4:0] ex_rs, ex_rt, ex_wreg;
  logic       mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg;
  logic [4:0] mem_wreg;
  logic       wb_regwrite, wb_memtoreg;
  logic [4:0] wb_wreg;
  logic       pc_hold, if_flush;
  logic [1:0] pc_src, fwd_a, fwd_b;

  ctrl_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .id_ctrl      (id_ctrl),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .mem_zero     (mem_zero),
    .ex_ctrl      (ex_ctrl),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_wreg      (ex_wreg),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .mem_regwrite (mem_regwrite),
    .mem_memtoreg (mem_memtoreg),
    .mem_wreg     (mem_wreg),
    .wb_regwrite  (wb_regwrite),
    .wb_memtoreg  (wb_memtoreg),
    .wb_wreg      (wb_wreg),
    .pc_hold      (pc_hold),
    .if_flush     (if_flush),
    .pc_src       (pc_src),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  ins_t m_ex = '0;
  ins_t m_mem = '0;
  ins_t m_wb = '0;
  bit   prev_hold = 1'b0;
  bit   prev_flush = 1'b0;

  function automatic logic [4:0] dest(input ins_t i);
    return i.c[9] ? i.rd : i.rt;
  endfunction

  function automatic bit hit(input logic en, input logic [4:0] w,
                             input logic [4:0] r);
    return en && (w != 0) && (w == r);
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] r);
`ifdef CTRL_PIPE_FWD_EN
    if (hit(m_mem.c[6], dest(m_mem), r)) return 2'b10;
    if (hit(m_wb.c[6], dest(m_wb), r)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic ctl_t eval();
    ctl_t e;
    e = '0;
    e.taken = m_mem.c[3] && mem_zero;
    e.stall = hit(m_ex.c[5], dest(m_ex), id_rs) ||
              hit(m_ex.c[5], dest(m_ex), id_rt);
`ifndef CTRL_PIPE_FWD_EN
    e.stall = e.stall ||
              hit(m_ex.c[6], dest(m_ex), id_rs) ||
              hit(m_ex.c[6], dest(m_ex), id_rt) ||
              hit(m_mem.c[6], dest(m_mem), id_rs) ||
              hit(m_mem.c[6], dest(m_mem), id_rt);
`endif
    e.hold  = e.stall && !e.taken;
    e.psrc  = e.taken ? 2'b01 :
              (id_ctrl[2] && !e.stall) ? 2'b10 : 2'b00;
    e.flush = (e.psrc != 2'b00);
    e.fa    = fsel(m_ex.rs);
    e.fb    = fsel(m_ex.rt);
    return e;
  endfunction

  always @(posedge clk) begin
    ctl_t e;
    ins_t id;
    e  = eval();
    id = '{c: id_ctrl, rs: id_rs, rt: id_rt, rd: id_rd};
    if (rst) begin
      m_ex = '0;
      m_mem = '0;
      m_wb = '0;
      prev_hold = 1'b0;
      prev_flush = 1'b0;
    end else begin
      prev_hold = e.hold;
      prev_flush = e.flush;
      m_wb  = m_mem;
      m_mem = e.taken ? '0 : m_ex;
      m_ex  = (e.taken || e.stall) ? '0 : id;
    end
  end

  task automatic cmp(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ctl_t e;
    #1;
    if (chk_en) begin
      e = eval();
      cmp("ex_stage", {ex_ctrl, ex_rs, ex_rt, ex_wreg},
          {m_ex.c, m_ex.rs, m_ex.rt, dest(m_ex)});
      cmp("mem_wb_stage",
          {mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg,
           mem_wreg, wb_regwrite, wb_memtoreg, wb_wreg},
          {m_mem.c[5], m_mem.c[4], m_mem.c[6], m_mem.c[7],
           dest(m_mem), m_wb.c[6], m_wb.c[7], dest(m_wb)});
      cmp("hazard", {pc_hold, if_flush, pc_src, fwd_a, fwd_b},
          {e.hold, e.flush, e.psrc, e.fa, e.fb});
    end
  end

  task automatic step(input logic [9:0] c, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic z);
    @(negedge clk);
    id_ctrl = c;
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
    mem_zero = z;
    #2;
  endtask

  task automatic nop();
    step(C_NOP, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    #2;
    cmp("rst_ex_ctrl", ex_ctrl, 0);
    cmp("rst_pc_src", pc_src, 0);
    cmp("rst_pc_hold", pc_hold, 0);
    cmp("rst_wb_wreg", wb_wreg, 0);

    // R-type through all stages
    step(C_R, 1, 7, 3, 0);
    nop();
    cmp("r_ex_wreg", ex_wreg, 3);
    cmp("r_ex_ctrl", ex_ctrl, C_R);
    nop();
    cmp("r_mem", {mem_regwrite, mem_wreg}, {1'b1, 5'd3});
    nop();
    cmp("r_wb", {wb_regwrite, wb_wreg}, {1'b1, 5'd3});

    // load-use
    step(C_LW, 2, 5, 0, 0);
    step(C_R, 5, 6, 8, 0);
    cmp("lu_hold", pc_hold, 1);
    step(C_R, 5, 6, 8, 0);
    cmp("lu_bubble", ex_ctrl, 0);
`ifdef CTRL_PIPE_FWD_EN
    cmp("lu_release", pc_hold, 0);
`else
    cmp("lu_hold2", pc_hold, 1);
    step(C_R, 5, 6, 8, 0);
    cmp("lu_release", pc_hold, 0);
`endif
    nop();
    cmp("lu_consumer", {ex_ctrl, ex_wreg}, {C_R, 5'd8});
    repeat (3) nop();

    // branch taken
    step(C_BEQ, 0, 0, 0, 0);
    step(C_R, 0, 0, 9, 0);
    step(C_R, 0, 0, 10, 1);
    cmp("br_take", {pc_src, if_flush}, {2'b01, 1'b1});
    nop();
    cmp("br_kill", {ex_ctrl, mem_regwrite, mem_wreg}, 0);
    // branch not taken
    step(C_BEQ, 0, 0, 0, 0);
    step(C_R, 0, 0, 9, 0);
    step(C_R, 0, 0, 10, 0);
    cmp("br_not", {pc_src, if_flush}, 0);
    nop();
    cmp("br_keep", {mem_regwrite, mem_wreg, ex_wreg},
        {1'b1, 5'd9, 5'd10});

    // jump
    step(C_J, 0, 0, 0, 0);
    cmp("j_take", {pc_src, if_flush, pc_hold}, {2'b10, 1'b1, 1'b0});
    nop();
    cmp("j_done", {pc_src, if_flush, ex_ctrl}, {2'b00, 1'b0, C_J});
    repeat (3) nop();

    // back-to-back RAW
    step(C_R, 0, 0, 3, 0);
    step(C_R, 3, 0, 4, 0);
`ifdef CTRL_PIPE_FWD_EN
    cmp("raw_nohold", pc_hold, 0);
    nop();
    cmp("fwd_a_mem", fwd_a, 2'b10);
`else
    cmp("raw_hold1", pc_hold, 1);
    step(C_R, 3, 0, 4, 0);
    cmp("raw_hold2", pc_hold, 1);
    step(C_R, 3, 0, 4, 0);
    cmp("raw_hold3", pc_hold, 0);
`endif
    repeat (3) nop();

    // RAW with one instruction between
    step(C_R, 0, 0, 3, 0);
    nop();
    step(C_R, 3, 0, 4, 0);
`ifdef CTRL_PIPE_FWD_EN
    nop();
    cmp("fwd_a_wb", fwd_a, 2'b01);
    step(C_R, 0, 0, 3, 0);
    step(C_R, 0, 3, 4, 0);
    nop();
    cmp("fwd_b_mem", fwd_b, 2'b10);
`else
    cmp("gap_hold", pc_hold, 1);
    step(C_R, 3, 0, 4, 0);
    cmp("gap_release", pc_hold, 0);
`endif
    repeat (3) nop();

    // $0 never forwards or stalls
    step(C_R, 0, 0, 0, 0);
    step(C_R, 0, 0, 4, 0);
    cmp("r0_hold", pc_hold, 0);
    nop();
    cmp("r0_fwd", fwd_a, 2'b00);
    repeat (3) nop();

    // reset with three in flight
    step(C_R, 0, 0, 3, 0);
    step(C_R, 0, 0, 4, 0);
    step(C_LW, 0, 5, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    id_ctrl = C_NOP;
    id_rs = 0;
    id_rt = 0;
    id_rd = 0;
    @(negedge clk);
    rst = 1'b0;
    id_ctrl = C_R;
    id_rs = 5;
    id_rt = 6;
    id_rd = 8;
    #2;
    cmp("rst_flush",
        {ex_ctrl, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg},
        0);
    cmp("rst_nostall", {pc_hold, pc_src}, 0);

    // randomized stream
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      mem_zero = 1'($urandom_range(0, 1));
      if (prev_hold) begin
      end else if (prev_flush) begin
        id_ctrl = C_NOP;
        id_rs = 0;
        id_rt = 0;
        id_rd = 0;
      end else begin
        k = $urandom_range(0, 5);
        case (k)
          0: id_ctrl = C_R;
          1: id_ctrl = C_LW;
          2: id_ctrl = C_SW;
          3: id_ctrl = C_BEQ;
          4: id_ctrl = C_J;
          default: id_ctrl = C_NOP;
        endcase
        id_rs = 5'($urandom_range(0, 3));
        id_rt = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
      end
    end

    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
